// File: rtl/control_sequencer.sv
// control_sequencer: multicycle fetch/execute control unit for the bus-based datapath.
// Define INSTR_COUNT_EN to add the instr_count retire counter output.
module control_sequencer #(
  parameter int OPW  = 5,
  parameter int RSEL = 4
) (
  input  logic                 clock,
  input  logic                 clear,
  input  logic                 run,
  input  logic [31:0]          ir,
  input  logic                 mem_ready,
  output logic                 pc_out,
  output logic                 mar_in,
  output logic                 inc_pc,
  output logic                 pc_in,
  output logic                 mem_read,
  output logic                 mdr_in,
  output logic                 mdr_out,
  output logic                 ir_in,
  output logic                 y_in,
  output logic                 z_in,
  output logic                 zlo_out,
  output logic                 zhi_out,
  output logic                 hi_in,
  output logic                 lo_in,
  output logic [2**RSEL-1:0]   reg_in_en,
  output logic [2**RSEL-1:0]   reg_out_en,
  output logic [OPW-1:0]       alu_op,
  output logic [3:0]           state,
  output logic                 halted,
  output logic                 illegal
`ifdef INSTR_COUNT_EN
  ,
  output logic [31:0]          instr_count
`endif
);
  localparam int NR = 2**RSEL;
  typedef enum logic [3:0] {
    IDLE = 4'h0, T0 = 4'h1, T1 = 4'h2, T2 = 4'h3, T3 = 4'h4,
    T4 = 4'h5, T5 = 4'h6, T6 = 4'h7, HALT = 4'h8
  } st_t;
  st_t st, nxt;
  logic first_t1, retire;
  logic [OPW-1:0] op;
  logic [RSEL-1:0] ra, rb, rc;
  logic is_alu, is_md, is_nop, is_hlt;
  logic [NR-1:0] one;
  assign one = NR'(1);
  assign op = ir[31 -: OPW];
  assign ra = ir[31-OPW -: RSEL];
  assign rb = ir[31-OPW-RSEL -: RSEL];
  assign rc = ir[31-OPW-2*RSEL -: RSEL];
  assign is_alu = op <= OPW'(11);
  assign is_md = op == OPW'(15) || op == OPW'(16);
  assign is_nop = op == OPW'(26);
  assign is_hlt = op == OPW'(27);
  assign state = st;
  always_ff @(posedge clock or negedge clear)
    if (!clear) begin
      st <= IDLE;
      first_t1 <= 1'b0;
      illegal <= 1'b0;
    end else begin
      st <= nxt;
      first_t1 <= st == T0;
      illegal <= illegal | (st == T3 && !(is_alu || is_md || is_nop || is_hlt));
    end
`ifdef INSTR_COUNT_EN
  always_ff @(posedge clock or negedge clear)
    if (!clear) instr_count <= '0;
    else instr_count <= instr_count + 32'(retire);
`endif
  always_comb begin
    nxt = st;
    retire = 1'b0;
    {pc_out, mar_in, inc_pc, pc_in, mem_read, mdr_in, mdr_out} = '0;
    {ir_in, y_in, z_in, zlo_out, zhi_out, hi_in, lo_in, halted} = '0;
    reg_in_en = '0;
    reg_out_en = '0;
    alu_op = '0;
    case (st)
      IDLE: nxt = run ? T0 : IDLE;
      T0: begin
        {pc_out, mar_in, inc_pc, z_in} = '1;
        nxt = T1;
      end
      T1: begin
        {zlo_out, mem_read, mdr_in} = '1;
        pc_in = first_t1;
        nxt = mem_ready ? T2 : T1;
      end
      T2: begin
        {mdr_out, ir_in} = '1;
        nxt = T3;
      end
      T3: begin
        y_in = is_alu || is_md;
        reg_out_en = is_alu ? one << rb : is_md ? one << ra : '0;
        retire = is_nop;
        nxt = (is_alu || is_md) ? T4 : is_nop ? (run ? T0 : IDLE) : HALT;
      end
      T4: begin
        z_in = 1'b1;
        alu_op = op;
        reg_out_en = one << (is_alu ? rc : rb);
        nxt = T5;
      end
      T5: begin
        zlo_out = 1'b1;
        lo_in = !is_alu;
        reg_in_en = is_alu ? one << ra : '0;
        retire = is_alu;
        nxt = is_alu ? (run ? T0 : IDLE) : T6;
      end
      T6: begin
        {zhi_out, hi_in} = '1;
        retire = 1'b1;
        nxt = run ? T0 : IDLE;
      end
      HALT: halted = 1'b1;
      default: nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: randomized instruction stream against a per-instruction trace model.
module tb_control_sequencer;
  typedef struct packed {
    logic [3:0]  st;
    logic [13:0] sb;
    logic [15:0] rin;
    logic [15:0] rout;
    logic [4:0]  aop;
    logic        h;
    logic        il;
`ifdef INSTR_COUNT_EN
    logic [31:0] cnt;
`endif
  } obs_t;
  localparam logic [13:0] PCO = 14'h2000, MARI = 14'h1000, INCPC = 14'h0800, PCI = 14'h0400;
  localparam logic [13:0] MRD = 14'h0200, MDRI = 14'h0100, MDRO = 14'h0080, IRI = 14'h0040;
  localparam logic [13:0] YI = 14'h0020, ZI = 14'h0010, ZLO = 14'h0008, ZHI = 14'h0004;
  localparam logic [13:0] HII = 14'h0002, LOI = 14'h0001;
  logic clock = 1'b1, clear = 1'b0, run = 1'b0, mem_ready = 1'b0;
  logic [31:0] ir = '0;
  logic pc_out, mar_in, inc_pc, pc_in, mem_read, mdr_in, mdr_out, ir_in;
  logic y_in, z_in, zlo_out, zhi_out, hi_in, lo_in, halted, illegal;
  logic [15:0] reg_in_en, reg_out_en;
  logic [4:0] alu_op;
  logic [3:0] state;
  obs_t act, exp_o, rst_o;
  obs_t q[$];
  int total = 0, bad = 0;
  logic m_ill = 1'b0, idle = 1'b1;
`ifdef INSTR_COUNT_EN
  logic [31:0] instr_count;
  logic [31:0] m_cnt = '0;
`endif
  always #5 clock = ~clock;
  control_sequencer dut (
    .clock(clock), .clear(clear), .run(run), .ir(ir), .mem_ready(mem_ready),
    .pc_out(pc_out), .mar_in(mar_in), .inc_pc(inc_pc), .pc_in(pc_in),
    .mem_read(mem_read), .mdr_in(mdr_in), .mdr_out(mdr_out), .ir_in(ir_in),
    .y_in(y_in), .z_in(z_in), .zlo_out(zlo_out), .zhi_out(zhi_out),
    .hi_in(hi_in), .lo_in(lo_in), .reg_in_en(reg_in_en), .reg_out_en(reg_out_en),
    .alu_op(alu_op), .state(state), .halted(halted), .illegal(illegal)
`ifdef INSTR_COUNT_EN
    , .instr_count(instr_count)
`endif
  );
  assign act = {state,
                {pc_out, mar_in, inc_pc, pc_in, mem_read, mdr_in, mdr_out,
                 ir_in, y_in, z_in, zlo_out, zhi_out, hi_in, lo_in},
                reg_in_en, reg_out_en, alu_op, halted, illegal
`ifdef INSTR_COUNT_EN
                , instr_count
`endif
               };
  always @(negedge clock)
    if (q.size() > 0) begin
      exp_o = q.pop_front();
      total++;
      if (act !== exp_o) begin
        bad++;
        $display("FAIL st%0d@%0t: got %h want %h", exp_o.st, $time, act, exp_o);
      end
    end
  initial begin
    #200000;
    $display("FAIL timeout: stimulus did not finish, total=%0d bad=%0d", total, bad);
    $finish;
  end
  function automatic logic coin();
    return 1'($urandom_range(0, 1));
  endfunction
  function automatic obs_t ex(input logic [3:0] s, input logic [13:0] b,
                              input logic [15:0] ri, input logic [15:0] ro, input logic [4:0] a);
    obs_t e;
    e.st = s; e.sb = b; e.rin = ri; e.rout = ro; e.aop = a;
    e.h = s == 4'd8;
    e.il = m_ill;
`ifdef INSTR_COUNT_EN
    e.cnt = m_cnt;
`endif
    return e;
  endfunction
  task automatic cyc(input logic r, input logic m, input obs_t e);
    run = r;
    mem_ready = m;
    q.push_back(e);
    @(posedge clock);
    #1;
  endtask
  task automatic pulse_clear();
    run = 1'b0;
    #2 clear = 1'b0;
    m_ill = 1'b0;
`ifdef INSTR_COUNT_EN
    m_cnt = '0;
`endif
    #1;
    rst_o = ex(0, 0, 0, 0, 0);
    total++;
    if (act !== rst_o) begin
      bad++;
      $display("FAIL async clear@%0t: got %h want %h", $time, act, rst_o);
    end
    q.push_back(rst_o);
    #3 clear = 1'b1;
    @(posedge clock);
    #1;
    idle = 1'b1;
  endtask
  task automatic instr(input logic [31:0] i, input int w, input logic r_end);
    logic [4:0] op;
    logic [15:0] ra, rb, rc;
    op = i[31:27];
    ra = 16'(1) << i[26:23];
    rb = 16'(1) << i[22:19];
    rc = 16'(1) << i[18:15];
    ir = i;
    if (idle) cyc(1'b1, coin(), ex(0, 0, 0, 0, 0));
    cyc(coin(), coin(), ex(1, PCO | MARI | INCPC | ZI, 0, 0, 0));
    for (int k = 0; k <= w; k++)
      cyc(coin(), k == w, ex(2, ZLO | MRD | MDRI | (k == 0 ? PCI : 14'h0), 0, 0, 0));
    cyc(coin(), coin(), ex(3, MDRO | IRI, 0, 0, 0));
    if (op <= 5'h0B) begin
      cyc(coin(), coin(), ex(4, YI, 0, rb, 0));
      cyc(coin(), coin(), ex(5, ZI, 0, rc, op));
      cyc(r_end, coin(), ex(6, ZLO, ra, 0, 0));
    end else if (op == 5'h0F || op == 5'h10) begin
      cyc(coin(), coin(), ex(4, YI, 0, ra, 0));
      cyc(coin(), coin(), ex(5, ZI, 0, rb, op));
      cyc(coin(), coin(), ex(6, ZLO | LOI, 0, 0, 0));
      cyc(r_end, coin(), ex(7, ZHI | HII, 0, 0, 0));
    end else if (op == 5'h1A) begin
      cyc(r_end, coin(), ex(4, 0, 0, 0, 0));
    end else begin
      cyc(coin(), coin(), ex(4, 0, 0, 0, 0));
      if (op != 5'h1B) m_ill = 1'b1;
      idle = 1'b0;
      return;
    end
`ifdef INSTR_COUNT_EN
    m_cnt++;
`endif
    idle = !r_end;
  endtask
  function automatic logic [31:0] rand_instr();
    int c;
    logic [4:0] op;
    c = $urandom_range(0, 2);
    op = c == 0 ? 5'($urandom_range(0, 11)) : c == 1 ? (coin() ? 5'h0F : 5'h10) : 5'h1A;
    return {op, 27'($urandom)};
  endfunction
  initial begin
    logic [4:0] bad_op;
    #2 q.push_back(ex(0, 0, 0, 0, 0));
    #5 clear = 1'b1;
    @(posedge clock);
    #1;
    repeat (2) cyc(1'b0, coin(), ex(0, 0, 0, 0, 0));
    instr(32'h0091_0000, 0, 1'b0);
    cyc(1'b0, coin(), ex(0, 0, 0, 0, 0));
    instr(32'h0091_0000, 3, 1'b1);
    instr(32'h78A0_0000, 0, 1'b1);
    instr(32'hD000_0000, 1, 1'b1);
    ir = 32'h0091_0000;
    cyc(1'b1, 1'b1, ex(1, PCO | MARI | INCPC | ZI, 0, 0, 0));
    cyc(1'b0, 1'b1, ex(2, ZLO | MRD | MDRI | PCI, 0, 0, 0));
    cyc(1'b0, 1'b1, ex(3, MDRO | IRI, 0, 0, 0));
    cyc(1'b0, 1'b1, ex(4, YI, 0, 16'h0004, 0));
    pulse_clear();
    repeat (2) cyc(1'b0, coin(), ex(0, 0, 0, 0, 0));
    for (int n = 0; n < 40; n++) begin
      if (idle && coin()) cyc(1'b0, coin(), ex(0, 0, 0, 0, 0));
      instr(rand_instr(), $urandom_range(0, 3), coin());
    end
    instr(32'hD800_0000, 0, 1'b1);
    repeat (20) cyc(1'b1, coin(), ex(8, 0, 0, 0, 0));
    pulse_clear();
    cyc(1'b0, coin(), ex(0, 0, 0, 0, 0));
    do bad_op = 5'($urandom_range(12, 31));
    while (bad_op == 5'h0F || bad_op == 5'h10 || bad_op == 5'h1A || bad_op == 5'h1B);
    instr({bad_op, 27'($urandom)}, $urandom_range(0, 2), 1'b1);
    repeat (5) cyc(1'b1, coin(), ex(8, 0, 0, 0, 0));
    pulse_clear();
    for (int n = 0; n < 3; n++) instr({5'($urandom_range(0, 11)), 27'($urandom)}, 0, 1'b1);
    instr(32'hD000_0000, 0, 1'b1);
    instr(32'hD800_0000, 0, 1'b1);
    repeat (3) cyc(1'b1, coin(), ex(8, 0, 0, 0, 0));
    pulse_clear();
    cyc(1'b0, coin(), ex(0, 0, 0, 0, 0));
    @(posedge clock);
    #1;
    if (bad != 0 || q.size() != 0) $display("FAIL: bad=%0d pending=%0d", bad, q.size());
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Multicycle control unit that steps the bus-based datapath through fetch and execute T-states.
- Drives the datapath registers: R0-R15, IR, HI, LO, MAR, plus PC, MDR, Y and Z.
- Decodes the IR and produces one-hot register in/out enables, bus-source strobes, ALU op and the memory read handshake.
- Sits between the instruction register and the datapath's register enables.

Parameters:
- OPW, 5, opcode width (IR[31:27]).
- RSEL, 4, register-field width (Ra=IR[26:23], Rb=IR[22:19], Rc=IR[18:15]).

Ports:
- clock, input, 1, system clock; all state changes on the rising edge.
- clear, input, 1, reset, asynchronous, active-low; 0 forces reset state immediately.
- run, input, 1, level; 1 allows fetch of the next instruction.
- ir, input, 32, current IR register contents.
- mem_ready, input, 1, memory read data valid.
- pc_out, mar_in, inc_pc, pc_in, output, 1 each, PC/MAR strobes.
- mem_read, mdr_in, mdr_out, ir_in, output, 1 each, memory/IR strobes.
- y_in, z_in, zlo_out, zhi_out, hi_in, lo_in, output, 1 each, ALU-side strobes.
- reg_in_en, output, 16, one-hot write enable for R0-R15.
- reg_out_en, output, 16, one-hot bus-drive enable for R0-R15.
- alu_op, output, 5, ALU operation (copy of opcode while z_in=1, else 0).
- state, output, 4, current T-state encoding.
- halted, output, 1, sequencer in HALT.
- illegal, output, 1, sticky illegal-opcode flag.

Behaviour:
- Reset (clear=0, async):
  - state=IDLE (4'h0).
  - All strobes, reg_in_en, reg_out_en, alu_op, halted and illegal = 0.
- All outputs except illegal are combinational decodes of state and ir. No strobe is asserted outside the states listed below.
- State encodings: IDLE=0, T0=1, T1=2, T2=3, T3=4, T4=5, T5=6, T6=7, HALT=8. Codes 9-15 go to IDLE on the next edge.
- IDLE: run=1 goes to T0; otherwise stay.
- T0: pc_out, mar_in, inc_pc, z_in (alu_op=0, add). Goes to T1.
- T1: zlo_out, pc_in, mem_read and mdr_in asserted.
  - mem_ready=0: stay in T1. pc_in is asserted only on the first T1 cycle (entry from T0).
  - mem_ready=1: go to T2.
- T2: mdr_out, ir_in. Goes to T3. The ir input is valid from T3 onward.
- Opcode classes:
  - ALU: opcodes 0x00-0x0B.
  - MULDIV: 0x0F (mul) and 0x10 (div).
  - NOP: 0x1A.
  - HALT: 0x1B.
  - All others are illegal.
- ALU class:
  - T3: reg_out_en[Rb], y_in.
  - T4: reg_out_en[Rc], z_in, alu_op=opcode.
  - T5: zlo_out, reg_in_en[Ra].
  - Retire.
- MULDIV class:
  - T3: reg_out_en[Ra], y_in.
  - T4: reg_out_en[Rb], z_in, alu_op=opcode.
  - T5: zlo_out, lo_in.
  - T6: zhi_out, hi_in.
  - Retire.
- NOP: retire from T3.
- HALT opcode: T3 goes to HALT.
- Illegal opcode: T3 goes to HALT and illegal is set.
- Retire: go to T0 if run=1, else IDLE. run is sampled only in IDLE and at retire; deasserting it mid-instruction does not abort.
- HALT: halted=1. Only clear exits HALT. run is ignored.
- illegal: sticky, cleared only by clear.
- Exactly one reg_out_en bit or none; same for reg_in_en. At most one bus source among pc_out, zlo_out, zhi_out, mdr_out and reg_out_en is active in any state.
- clear asserted mid-instruction aborts immediately. No partial strobes after clear rises; the next edge with run=1 starts at T0.
- Latency, ignoring memory wait:
  - ALU: 6 cycles.
  - MULDIV: 7 cycles.
  - NOP: 4 cycles.
  - Each mem_ready=0 cycle in T1 adds one cycle.

Optional Feature:
- Macro: INSTR_COUNT_EN.
- Defined:
  - Adds output instr_count, 32 bits, reset to 0.
  - Increments by 1 on each retire (ALU, MULDIV, NOP); HALT and illegal do not count.
  - Wraps 0xFFFFFFFF to 0.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Test Plan:
1. clear=0 pulsed asynchronously between edges -> state=0 and all strobes 0 immediately; run=0 afterwards holds IDLE.
2. run=1, mem_ready=1, ir=0x00910000 (add Ra=1, Rb=2, Rc=2) -> states 1,2,3,4,5,6:
   - reg_out_en=0x0004 with y_in at T3.
   - reg_out_en=0x0004 with z_in and alu_op=0 at T4.
   - reg_in_en=0x0002 with zlo_out at T5.
   - Then back to T0.
3. Fetch with mem_ready held 0 for 3 cycles -> state stays 2 for 4 cycles with mem_read=1; pc_in pulses only in the first of them; then T2 with ir_in=1.
4. ir=0x78A00000 (mul Ra=1, Rb=4):
   - T3: reg_out_en=0x0002.
   - T4: reg_out_en=0x0010, alu_op=0x0F.
   - T5: lo_in=1.
   - T6: hi_in=1.
   - Total 7 cycles from T0.
5. ir=0xD8000000 (halt) -> HALT (state=8) with halted=1 and illegal=0, held for 20 cycles with run=1. ir=0xF8000000 (illegal opcode) -> HALT with illegal=1.
6. With INSTR_COUNT_EN: 3 ALU instructions plus 1 NOP then halt -> instr_count=4; clear -> 0.
